// File: rtl/act_collector.sv
// act_collector: buffers one layer of ReLU activations and then streams them
// to the next layer over a valid/ready handshake. Every activation pulse is
// edge-detected, so a pulse is counted once however long it is held high.
// All outputs come straight from flops. Their next values are computed from
// the next state, so out_valid rises in the cycle right after the capture
// that completes the layer.
module act_collector #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          act_done,
  input  logic [15:0]   act_data,
  input  logic          start,
  input  logic [AW:0]   layer_len,
  output logic [15:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          layer_done,
  output logic          overflow,
  output logic          len_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

  state_t        state_r, state_nx_s;
  logic [AW:0]   wr_r, wr_nx_s;
  logic [AW:0]   rd_r, rd_nx_s;
  logic [AW:0]   len_r, len_nx_s;
  logic          act_q_r;
  logic          cap_s;
  logic          wr_en_s;
  logic          ovf_r, ovf_nx_s;
  logic          lerr_r, lerr_nx_s;
  logic          drain_nx_s;
  logic          last_nx_s;
  logic [15:0]   data_nx_s;
  logic          out_valid_r, out_last_r, busy_r, layer_done_r;
  logic [15:0]   out_data_r;
  logic [15:0]   mem_r [DEPTH];

  // A capture event is the rising edge of act_done.
  assign cap_s = act_done & ~act_q_r;

  // Next-state, pointer, flag and next-output computation.
  always_comb begin
    state_nx_s = state_r;
    wr_nx_s    = wr_r;
    rd_nx_s    = rd_r;
    len_nx_s   = len_r;
    wr_en_s    = 1'b0;
    lerr_nx_s  = lerr_r;
    // A capture outside COLLECT has nowhere to go and is flagged as lost.
    ovf_nx_s   = ovf_r | (cap_s & (state_r != COLLECT));
    case (state_r)
      IDLE: begin
        if (start) begin
          if ((layer_len != {(AW + 1){1'b0}}) && (layer_len <= DEPTH_C)) begin
            len_nx_s   = layer_len;
            wr_nx_s    = {(AW + 1){1'b0}};
            rd_nx_s    = {(AW + 1){1'b0}};
            state_nx_s = COLLECT;
          end else begin
            lerr_nx_s  = 1'b1;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      COLLECT: begin
        if (cap_s) begin
          wr_en_s = 1'b1;
          wr_nx_s = wr_r + ONE_C;
          if ((wr_r + ONE_C) == len_r) begin
            state_nx_s = DRAIN;
          end else begin
            state_nx_s = COLLECT;
          end
        end else begin
          state_nx_s = COLLECT;
        end
      end
      DRAIN: begin
        if (out_valid_r && out_ready) begin
          rd_nx_s = rd_r + ONE_C;
          if (out_last_r) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = DRAIN;
          end
        end else begin
          state_nx_s = DRAIN;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase

    drain_nx_s = (state_nx_s == DRAIN);
    last_nx_s  = drain_nx_s && (rd_nx_s == (len_nx_s - ONE_C));
    if (!drain_nx_s) begin
      data_nx_s = 16'h0000;
    end else if (wr_en_s && (wr_r == rd_nx_s)) begin
      // A one-word layer reads the word that is being written this cycle.
      data_nx_s = act_data;
    end else begin
      data_nx_s = mem_r[rd_nx_s[AW-1:0]];
    end
  end

  // State, pointers, edge detector, sticky flags and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      wr_r         <= {(AW + 1){1'b0}};
      rd_r         <= {(AW + 1){1'b0}};
      len_r        <= {(AW + 1){1'b0}};
      act_q_r      <= 1'b0;
      ovf_r        <= 1'b0;
      lerr_r       <= 1'b0;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      out_data_r   <= 16'h0000;
      busy_r       <= 1'b0;
      layer_done_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      wr_r         <= wr_nx_s;
      rd_r         <= rd_nx_s;
      len_r        <= len_nx_s;
      act_q_r      <= act_done;
      ovf_r        <= ovf_nx_s;
      lerr_r       <= lerr_nx_s;
      out_valid_r  <= drain_nx_s;
      out_last_r   <= last_nx_s;
      out_data_r   <= data_nx_s;
      busy_r       <= (state_nx_s != IDLE);
      layer_done_r <= (state_nx_s == DONE);
    end
  end

  // Activation buffer; contents are only ever exposed while draining.
  always_ff @(posedge clk) begin
    if (rst && wr_en_s) begin
      mem_r[wr_r[AW-1:0]] <= act_data;
    end
  end

  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign out_last   = out_last_r;
  assign busy       = busy_r;
  assign layer_done = layer_done_r;
  assign overflow   = ovf_r;
  assign len_err    = lerr_r;

endmodule

// File: tb/tb_act_collector.sv
// Self-checking bench for act_collector: directed layer scenarios followed by
// random traffic, all compared cycle by cycle against a queue-based model.
module tb_act_collector;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  localparam int P_IDLE    = 0;
  localparam int P_COLLECT = 1;
  localparam int P_DRAIN   = 2;
  localparam int P_DONE    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          act_done;
  logic [15:0]   act_data;
  logic          start;
  logic [AW:0]   layer_len;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          layer_done;
  logic          overflow;
  logic          len_err;

  act_collector #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .act_done   (act_done),
    .act_data   (act_data),
    .start      (start),
    .layer_len  (layer_len),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .layer_done (layer_done),
    .overflow   (overflow),
    .len_err    (len_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int          m_phase = P_IDLE;
  int          m_len   = 0;
  logic [15:0] m_q[$];
  logic        m_prev  = 1'b0;
  logic        m_ovf   = 1'b0;
  logic        m_lerr  = 1'b0;

  // Words actually handed over by the DUT.
  logic [15:0] obs_q[$];
  logic [15:0] sent_q[$];
  logic        seen_valid = 1'b0;
  logic [15:0] seen_data  = 16'h0000;

  task automatic check_eq(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    n_checks++;
    if (observed === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    logic cap;
    cap    = act_done && !m_prev;
    m_prev = act_done;
    if (!rst) begin
      m_phase = P_IDLE;
      m_len   = 0;
      m_q.delete();
      m_prev  = 1'b0;
      m_ovf   = 1'b0;
      m_lerr  = 1'b0;
      return;
    end
    case (m_phase)
      P_IDLE: begin
        if (cap) m_ovf = 1'b1;
        if (start) begin
          if (int'(layer_len) >= 1 && int'(layer_len) <= DEPTH) begin
            m_len = int'(layer_len);
            m_q.delete();
            m_phase = P_COLLECT;
          end else begin
            m_lerr = 1'b1;
          end
        end
      end
      P_COLLECT: begin
        if (cap) begin
          m_q.push_back(act_data);
          if (m_q.size() == m_len) m_phase = P_DRAIN;
        end
      end
      P_DRAIN: begin
        if (cap) m_ovf = 1'b1;
        if (out_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_phase = P_DONE;
        end
      end
      default: begin
        if (cap) m_ovf = 1'b1;
        m_phase = P_IDLE;
      end
    endcase
  endtask

  task automatic compare_all();
    logic        e_valid;
    logic [15:0] e_data;
    e_valid = (m_phase == P_DRAIN);
    e_data  = e_valid ? m_q[0] : 16'h0000;
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
    check_eq("out_data", {16'd0, out_data}, {16'd0, e_data});
    check_eq("out_last", {31'd0, out_last}, {31'd0, (e_valid && m_q.size() == 1)});
    check_eq("busy", {31'd0, busy}, {31'd0, (m_phase != P_IDLE)});
    check_eq("layer_done", {31'd0, layer_done}, {31'd0, (m_phase == P_DONE)});
    check_eq("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check_eq("len_err", {31'd0, len_err}, {31'd0, m_lerr});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst && seen_valid && out_ready) obs_q.push_back(seen_data);
    model_step();
    @(negedge clk);
    compare_all();
    seen_valid = out_valid;
    seen_data  = out_data;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_layer(input int n);
    start     = 1'b1;
    layer_len = (AW + 1)'(n);
    tick();
    start     = 1'b0;
  endtask

  task automatic pulse(input logic [15:0] v);
    act_done = 1'b1;
    act_data = v;
    tick();
    act_done = 1'b0;
    act_data = 16'($urandom);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    act_done  = 1'b0;
    act_data  = 16'h0000;
    start     = 1'b0;
    layer_len = '0;
    out_ready = 1'b1;
    ticks(2);
    rst = 1'b1;
    tick();

    // Three-word layer with boundary data values, full-rate drain.
    obs_q.delete();
    start_layer(3);
    pulse(16'h0005);
    pulse(16'h0000);
    pulse(16'h7FFF);
    ticks(6);
    check_eq("s1_count", obs_q.size(), 32'd3);
    if (obs_q.size() == 3) begin
      check_eq("s1_w0", {16'd0, obs_q[0]}, 32'h0005);
      check_eq("s1_w1", {16'd0, obs_q[1]}, 32'h0000);
      check_eq("s1_w2", {16'd0, obs_q[2]}, 32'h7FFF);
    end

    // Long act_done pulse counts once.
    obs_q.delete();
    start_layer(2);
    act_done = 1'b1;
    act_data = 16'h0011;
    ticks(4);
    act_done = 1'b0;
    tick();
    pulse(16'h0022);
    ticks(5);
    check_eq("s2_count", obs_q.size(), 32'd2);
    if (obs_q.size() == 2) begin
      check_eq("s2_w0", {16'd0, obs_q[0]}, 32'h0011);
      check_eq("s2_w1", {16'd0, obs_q[1]}, 32'h0022);
    end

    // Full-depth layer drained with out_ready toggling.
    obs_q.delete();
    sent_q.delete();
    start_layer(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      sent_q.push_back(v);
      pulse(v);
    end
    for (int i = 0; i < 2 * DEPTH + 6; i++) begin
      out_ready = (i % 2 == 0);
      tick();
    end
    out_ready = 1'b1;
    check_eq("s3_count", obs_q.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < obs_q.size(); i++) begin
      check_eq("s3_word", {16'd0, obs_q[i]}, {16'd0, sent_q[i]});
    end

    // Activation arriving while draining sets sticky overflow.
    out_ready = 1'b0;
    start_layer(3);
    pulse(16'h1111);
    pulse(16'h2222);
    pulse(16'h3333);
    pulse(16'hDEAD);
    out_ready = 1'b1;
    ticks(8);
    do_reset();
    tick();

    // Illegal lengths, then a legal single-word layer.
    start_layer(0);
    tick();
    start_layer(DEPTH + 1);
    tick();
    start_layer(1);
    pulse(16'hBEEF);
    ticks(4);

    // Reset in the middle of collecting, then a fresh layer.
    do_reset();
    start_layer(4);
    pulse(16'hAAAA);
    pulse(16'h5555);
    do_reset();
    start_layer(4);
    for (int i = 0; i < 4; i++) pulse(16'(16'h0100 + i));
    ticks(8);

    // act_done already high when reset is released.
    act_done = 1'b1;
    do_reset();
    tick();
    act_done = 1'b0;
    ticks(2);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 199) != 0);
      start     = ($urandom_range(0, 7) == 0);
      layer_len = (AW + 1)'($urandom_range(0, DEPTH + 1));
      if ($urandom_range(0, 2) == 0) act_done = ~act_done;
      act_data  = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
